ecc_mem_controller: RTL and testbench
=====================================

Name: ecc_mem_controller

Overview:
- Sequences processor read/write transactions through the ECC/bypass datapath into the dual 16-bit memories (up/down).
- Drives the datapath mode select, memory strobes and address, and captures decoded read data and flags.
- Counts corrected and uncorrectable errors and optionally scrubs by writing corrected data back.
- Sits between the processor bus and the ECC datapath. One transaction is in flight at a time.

Parameters:
- ADDR_W, 8, memory word address width.
- MEM_LAT, 2, memory read latency in cycles from mem_re to valid read data at the datapath (legal range 1..7).
- CNT_W, 16, width of the error counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  processor request valid.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_mode  in  2  00 bypass mem up, 01 bypass mem down, 10 ECC, 11 ECC with 0-3 error injection.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  16  write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  processor accepts the response.
- rsp_rdata  out  16  read data (0 for writes).
- rsp_flag  out  3  decoder flag for reads (0 for writes and bypass reads).
- ecc_sel  out  2  datapath mode select.
- dp_wdata  out  16  datapath processor-side input.
- dp_rdata  in  16  datapath processor-side output.
- dp_flag  in  3  decoder flag.
- mem_addr  out  ADDR_W  address to both memories.
- mem_we_up  out  1  write strobe, memory up.
- mem_we_down  out  1  write strobe, memory down.
- mem_re  out  1  read strobe, both memories.
- scrub_en  in  1  enable write-back of corrected reads.
- cnt_clr  in  1  clear both counters.
- corr_cnt  out  CNT_W  corrected-error count, saturating.
- uncorr_cnt  out  CNT_W  uncorrectable-error count, saturating.

Behaviour:
- Flag classes:
  - dp_flag == 3'b000: clean.
  - dp_flag[2] == 1: uncorrectable.
  - Otherwise: corrected.
- Reset values:
  - State IDLE.
  - req_ready=1, rsp_valid=0.
  - rsp_rdata, rsp_flag, dp_wdata, mem_addr = 0.
  - All strobes 0.
  - ecc_sel=2'b10.
  - Counters 0.
  - Reset mid-transaction aborts it: no response is issued and no strobe is asserted in the following cycle.
- FSM states: IDLE, WRITE, RD_WAIT, RD_CAP, SCRUB, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we, mode, addr and wdata, and set ecc_sel=mode.
  - Next state is WRITE if we=1, otherwise RD_WAIT.
  - ecc_sel holds the last latched mode outside active transactions.
- WRITE (1 cycle):
  - dp_wdata = latched data; mem_addr = latched addr.
  - Strobes by mode: mode 00 asserts mem_we_up only; 01 asserts mem_we_down only; 10 and 11 assert both.
  - Next: RESP with rsp_rdata=0 and rsp_flag=0.
- RD_WAIT:
  - mem_re=1 in the first cycle only.
  - A latency counter runs MEM_LAT cycles.
  - Next: RD_CAP.
  - Total read latency is MEM_LAT+1 cycles from accept to RD_CAP.
- RD_CAP (1 cycle):
  - Sample dp_rdata.
  - Sample the flag: dp_flag in modes 10/11, forced to 0 in modes 00/01.
  - Increment the appropriate counter.
  - If the flag is corrected, scrub_en=1 and the mode is ECC, go to SCRUB; otherwise go to RESP.
- SCRUB (1 cycle):
  - ecc_sel=2'b10 (never inject errors during a scrub).
  - dp_wdata = captured data; same address; both write strobes asserted.
  - Next: RESP.
  - ecc_sel returns to the latched mode afterwards.
- RESP:
  - rsp_valid=1, with rsp_rdata and rsp_flag held stable until rsp_ready.
  - On rsp_ready, go to IDLE; req_ready goes to 1 in the next cycle.
  - No request is accepted while in RESP.
- Counters:
  - Saturate at all-ones (no wrap).
  - cnt_clr has priority over a same-cycle increment: the result is 0.
  - An uncorrectable error never scrubs.
- Strobes never overlap: mem_re and mem_we_* are mutually exclusive in every cycle.

Decomposition:
- Package ecc_ctrl_pkg:
  - Mode enum: MODE_BYP_UP, MODE_BYP_DN, MODE_ECC, MODE_ECC_INJ.
  - State enum.
  - Flag constants: FLAG_CLEAN=3'b000, FLAG_UNCORR_BIT=2.
  - Function classify_flag.
- Sub-module ecc_err_counter: one saturating counter with clear and increment, instantiated twice.

Test Plan:
- Write, mode 10, addr 0x05, data 0xA5A5:
  - Exactly one cycle with mem_we_up=mem_we_down=1, ecc_sel=10, dp_wdata=0xA5A5.
  - Then rsp_valid with rsp_rdata=0.
- Read, mode 00, MEM_LAT=2, dp_rdata=0x1234, dp_flag=3'b001:
  - rsp_rdata=0x1234 and rsp_flag=0 after MEM_LAT+1 cycles.
  - No counter changes.
  - mem_re high for one cycle only.
- Read, mode 10, dp_flag=3'b001, dp_rdata=0xBEEF, scrub_en=1:
  - corr_cnt goes 0→1.
  - SCRUB cycle with both write strobes, ecc_sel=10, dp_wdata=0xBEEF, same address.
  - Then response.
- Read, mode 11, dp_flag=3'b100:
  - uncorr_cnt=1, no scrub even with scrub_en=1, rsp_flag=3'b100.
- Hold rsp_ready=0 for 5 cycles:
  - rsp_valid and rsp_rdata stay stable and req_ready stays 0.
  - A new req_valid is ignored until one cycle after rsp_ready.
- Boundaries:
  - Preload corr_cnt=0xFFFF and issue a corrected read: the count stays at 0xFFFF.
  - Assert cnt_clr together with a corrected read: the count becomes 0.
  - Assert rst during RD_WAIT: the next cycle is IDLE, all strobes are 0, and no rsp_valid occurs.

Source files
------------

// File: rtl/ecc_ctrl_pkg.sv
// Shared types, flag constants and flag classification for the ECC memory controller.
package ecc_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_BYP_UP  = 2'b00,
        MODE_BYP_DN  = 2'b01,
        MODE_ECC     = 2'b10,
        MODE_ECC_INJ = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_RD_CAP  = 3'd3,
        ST_SCRUB   = 3'd4,
        ST_RESP    = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        FC_CLEAN  = 2'd0,
        FC_CORR   = 2'd1,
        FC_UNCORR = 2'd2
    } flag_class_e;

    localparam logic [2:0] FLAG_CLEAN      = 3'b000;
    localparam int         FLAG_UNCORR_BIT = 2;

    // Uncorrectable wins over any other nonzero flag pattern.
    function automatic flag_class_e classify_flag(input logic [2:0] flag);
        flag_class_e cls;
        if (flag[FLAG_UNCORR_BIT]) begin
            cls = FC_UNCORR;
        end else if (flag == FLAG_CLEAN) begin
            cls = FC_CLEAN;
        end else begin
            cls = FC_CORR;
        end
        return cls;
    endfunction

endpackage

// File: rtl/ecc_mem_controller_err_counter.sv
// Saturating error counter; clear takes priority over increment.
module ecc_err_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Count register: hold at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (clr) begin
            count_r <= {W{1'b0}};
        end else if (inc && (count_r != {W{1'b1}})) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/ecc_mem_controller.sv
// Transaction sequencer between the processor bus and the ECC/bypass datapath,
// with error counting and optional scrub write-back of corrected reads.
module ecc_mem_controller
    import ecc_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_mode,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [15:0]       rsp_rdata,
    output logic [2:0]        rsp_flag,
    output logic [1:0]        ecc_sel,
    output logic [15:0]       dp_wdata,
    input  logic [15:0]       dp_rdata,
    input  logic [2:0]        dp_flag,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we_up,
    output logic              mem_we_down,
    output logic              mem_re,
    input  logic              scrub_en,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    localparam logic [2:0] S_IDLE    = ST_IDLE;
    localparam logic [2:0] S_WRITE   = ST_WRITE;
    localparam logic [2:0] S_RD_WAIT = ST_RD_WAIT;
    localparam logic [2:0] S_RD_CAP  = ST_RD_CAP;
    localparam logic [2:0] S_SCRUB   = ST_SCRUB;
    localparam logic [2:0] S_RESP    = ST_RESP;
    localparam logic [2:0] LAT_INIT  = 3'(MEM_LAT - 1);

    logic [2:0]        state_r;
    logic [1:0]        mode_r;
    logic [2:0]        lat_r;
    logic              req_ready_r;
    logic              rsp_valid_r;
    logic [15:0]       rsp_rdata_r;
    logic [2:0]        rsp_flag_r;
    logic [1:0]        ecc_sel_r;
    logic [15:0]       dp_wdata_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              mem_we_up_r;
    logic              mem_we_down_r;
    logic              mem_re_r;

    logic [2:0]        flag_eff_s;
    flag_class_e       fclass_s;
    logic              corr_inc_s;
    logic              uncorr_inc_s;
    logic              scrub_go_s;

    // Effective read flag (bypass reads carry no ECC status) and its counter/scrub effects.
    always_comb begin
        flag_eff_s   = FLAG_CLEAN;
        corr_inc_s   = 1'b0;
        uncorr_inc_s = 1'b0;
        scrub_go_s   = 1'b0;
        if (mode_r[1]) begin
            flag_eff_s = dp_flag;
        end else begin
            flag_eff_s = FLAG_CLEAN;
        end
        fclass_s = classify_flag(flag_eff_s);
        if (state_r == S_RD_CAP) begin
            corr_inc_s   = (fclass_s == FC_CORR);
            uncorr_inc_s = (fclass_s == FC_UNCORR);
            scrub_go_s   = (fclass_s == FC_CORR) && scrub_en;
        end else begin
            corr_inc_s   = 1'b0;
            uncorr_inc_s = 1'b0;
            scrub_go_s   = 1'b0;
        end
    end

    // Transaction FSM; strobes default low so each one lasts a single cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_IDLE;
            mode_r        <= MODE_ECC;
            lat_r         <= 3'd0;
            req_ready_r   <= 1'b1;
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= 16'h0000;
            rsp_flag_r    <= 3'b000;
            ecc_sel_r     <= MODE_ECC;
            dp_wdata_r    <= 16'h0000;
            mem_addr_r    <= {ADDR_W{1'b0}};
            mem_we_up_r   <= 1'b0;
            mem_we_down_r <= 1'b0;
            mem_re_r      <= 1'b0;
        end else begin
            mem_we_up_r   <= 1'b0;
            mem_we_down_r <= 1'b0;
            mem_re_r      <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (req_valid) begin
                        mode_r      <= req_mode;
                        ecc_sel_r   <= req_mode;
                        mem_addr_r  <= req_addr;
                        req_ready_r <= 1'b0;
                        if (req_we) begin
                            state_r       <= S_WRITE;
                            dp_wdata_r    <= req_wdata;
                            mem_we_up_r   <= (req_mode != MODE_BYP_DN);
                            mem_we_down_r <= (req_mode != MODE_BYP_UP);
                        end else begin
                            state_r  <= S_RD_WAIT;
                            mem_re_r <= 1'b1;
                            lat_r    <= LAT_INIT;
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                S_WRITE: begin
                    state_r     <= S_RESP;
                    rsp_valid_r <= 1'b1;
                    rsp_rdata_r <= 16'h0000;
                    rsp_flag_r  <= 3'b000;
                end
                S_RD_WAIT: begin
                    if (lat_r == 3'd0) begin
                        state_r <= S_RD_CAP;
                    end else begin
                        lat_r <= lat_r - 3'd1;
                    end
                end
                S_RD_CAP: begin
                    rsp_rdata_r <= dp_rdata;
                    rsp_flag_r  <= flag_eff_s;
                    if (scrub_go_s) begin
                        // Scrub always writes through the plain ECC path, never the injector.
                        state_r       <= S_SCRUB;
                        ecc_sel_r     <= MODE_ECC;
                        dp_wdata_r    <= dp_rdata;
                        mem_we_up_r   <= 1'b1;
                        mem_we_down_r <= 1'b1;
                    end else begin
                        state_r     <= S_RESP;
                        rsp_valid_r <= 1'b1;
                    end
                end
                S_SCRUB: begin
                    state_r     <= S_RESP;
                    ecc_sel_r   <= mode_r;
                    rsp_valid_r <= 1'b1;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_r     <= S_IDLE;
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                    end else begin
                        rsp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    rsp_valid_r <= 1'b0;
                    req_ready_r <= 1'b1;
                end
            endcase
        end
    end

    ecc_err_counter #(.W(CNT_W)) u_corr_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (corr_inc_s),
        .count (corr_cnt)
    );

    ecc_err_counter #(.W(CNT_W)) u_uncorr_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (uncorr_inc_s),
        .count (uncorr_cnt)
    );

    assign req_ready   = req_ready_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_flag    = rsp_flag_r;
    assign ecc_sel     = ecc_sel_r;
    assign dp_wdata    = dp_wdata_r;
    assign mem_addr    = mem_addr_r;
    assign mem_we_up   = mem_we_up_r;
    assign mem_we_down = mem_we_down_r;
    assign mem_re      = mem_re_r;

endmodule

// File: tb/tb_ecc_mem_controller.sv
// Scoreboard bench for ecc_mem_controller with a MEM_LAT-cycle memory/datapath model.
module tb_ecc_mem_controller;

    localparam int MEM_LAT = 2;
    localparam int CNT_W   = 4;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_we, rsp_ready, scrub_en, cnt_clr;
    logic        req_ready, rsp_valid, mem_we_up, mem_we_down, mem_re;
    logic [1:0]  req_mode, ecc_sel;
    logic [7:0]  req_addr, mem_addr;
    logic [15:0] req_wdata, rsp_rdata, dp_wdata, dp_rdata;
    logic [2:0]  rsp_flag, dp_flag;
    logic [CNT_W-1:0] corr_cnt, uncorr_cnt;

    logic [15:0] rd_val  = 16'h0000;
    logic [2:0]  rd_flag = 3'b000;
    logic [MEM_LAT-1:0] re_pipe = '0;

    typedef struct { logic [15:0] rdata; logic [2:0] flag; } exp_t;
    exp_t exp_q[$];
    exp_t ex;

    int n_tests = 0;
    int n_fail  = 0;
    int mon_both = 0, mon_up = 0, mon_dn = 0, mon_re = 0, mon_ovl = 0;
    logic [15:0] last_wdata = 16'h0000;
    logic [1:0]  last_sel   = 2'b00;
    logic [7:0]  last_addr  = 8'h00;

    always #5 clk = ~clk;

    ecc_mem_controller #(.ADDR_W(8), .MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_flag(rsp_flag),
        .ecc_sel(ecc_sel), .dp_wdata(dp_wdata), .dp_rdata(dp_rdata), .dp_flag(dp_flag),
        .mem_addr(mem_addr), .mem_we_up(mem_we_up), .mem_we_down(mem_we_down), .mem_re(mem_re),
        .scrub_en(scrub_en), .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    // Memory model: read data is only valid MEM_LAT cycles after the mem_re cycle.
    always @(posedge clk) re_pipe <= {re_pipe[MEM_LAT-2:0], mem_re};
    assign dp_rdata = re_pipe[MEM_LAT-1] ? rd_val  : 16'hDEAD;
    assign dp_flag  = re_pipe[MEM_LAT-1] ? rd_flag : 3'b000;

    // Strobe monitor.
    always @(negedge clk) begin
        if (mem_we_up && mem_we_down) mon_both++;
        else if (mem_we_up) mon_up++;
        else if (mem_we_down) mon_dn++;
        if (mem_re) mon_re++;
        if (mem_re && (mem_we_up || mem_we_down)) mon_ovl++;
        if (mem_we_up || mem_we_down) begin
            last_wdata = dp_wdata; last_sel = ecc_sel; last_addr = mem_addr;
        end
    end

    task automatic issue(input logic we, input logic [1:0] mode, input logic [7:0] addr,
                         input logic [15:0] wdata);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 40) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_we = we; req_mode = mode; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int cyc, output bit seen);
        seen = 1'b0; cyc = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk); cyc++;
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic ack();
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({req_ready, rsp_valid, mem_we_up, mem_we_down, mem_re} !== 5'b10000) begin
            n_fail++; $display("FAIL reset_ctrl: got rdy/vld/strobes=%b want 10000",
                               {req_ready, rsp_valid, mem_we_up, mem_we_down, mem_re});
        end
        n_tests++;
        if (ecc_sel !== 2'b10 || corr_cnt !== 4'h0 || uncorr_cnt !== 4'h0) begin
            n_fail++; $display("FAIL reset_sel_cnt: got sel=%b corr=%h uncorr=%h want 10 0 0",
                               ecc_sel, corr_cnt, uncorr_cnt);
        end
        n_tests++;
        if (rsp_rdata !== 16'h0 || rsp_flag !== 3'b0 || dp_wdata !== 16'h0 || mem_addr !== 8'h0) begin
            n_fail++; $display("FAIL reset_data: got rdata=%h flag=%b wdata=%h addr=%h want zeros",
                               rsp_rdata, rsp_flag, dp_wdata, mem_addr);
        end
    endtask

    task automatic test_write();
        logic [1:0]  modes [3] = '{2'b10, 2'b00, 2'b01};
        logic [7:0]  addrs [3] = '{8'h05, 8'h31, 8'hC2};
        logic [15:0] datas [3] = '{16'hA5A5, 16'h1357, 16'hFACE};
        for (int i = 0; i < 3; i++) begin
            int b0 = mon_both, u0 = mon_up, d0 = mon_dn, cyc;
            bit seen;
            logic [2:0] exp_str;
            exp_str = {modes[i][1], modes[i] == 2'b00, modes[i] == 2'b01};
            exp_q.push_back('{16'h0000, 3'b000});
            issue(1'b1, modes[i], addrs[i], datas[i]);
            wait_rsp(cyc, seen);
            ex = exp_q.pop_front();
            n_tests++;
            if (!seen || cyc != 2 || rsp_rdata !== ex.rdata || rsp_flag !== ex.flag) begin
                n_fail++; $display("FAIL write_rsp[%0d]: got seen=%0b lat=%0d data=%h flag=%b want lat=2 data=%h flag=%b",
                                   i, seen, cyc, rsp_rdata, rsp_flag, ex.rdata, ex.flag);
            end
            ack();
            n_tests++;
            if ({mon_both - b0 == 1, mon_up - u0 == 1, mon_dn - d0 == 1} !== exp_str ||
                (mon_both - b0) + (mon_up - u0) + (mon_dn - d0) != 1) begin
                n_fail++; $display("FAIL write_strobes[%0d]: got both=%0d up=%0d dn=%0d want pattern %b",
                                   i, mon_both - b0, mon_up - u0, mon_dn - d0, exp_str);
            end
            n_tests++;
            if (last_wdata !== datas[i] || last_sel !== modes[i] || last_addr !== addrs[i]) begin
                n_fail++; $display("FAIL write_bus[%0d]: got wdata=%h sel=%b addr=%h want %h %b %h",
                                   i, last_wdata, last_sel, last_addr, datas[i], modes[i], addrs[i]);
            end
        end
    endtask

    task automatic test_bypass_read();
        int r0 = mon_re, w0 = mon_both + mon_up + mon_dn, cyc;
        bit seen;
        scrub_en = 1'b1; rd_val = 16'h1234; rd_flag = 3'b001;
        exp_q.push_back('{16'h1234, 3'b000});
        issue(1'b0, 2'b00, 8'h10, 16'h0000);
        wait_rsp(cyc, seen);
        ex = exp_q.pop_front();
        n_tests++;
        if (!seen || cyc != MEM_LAT + 2 || rsp_rdata !== ex.rdata || rsp_flag !== ex.flag) begin
            n_fail++; $display("FAIL bypass_rsp: got seen=%0b lat=%0d data=%h flag=%b want lat=%0d data=%h flag=%b",
                               seen, cyc, rsp_rdata, rsp_flag, MEM_LAT + 2, ex.rdata, ex.flag);
        end
        ack();
        n_tests++;
        if (mon_re - r0 != 1 || mon_both + mon_up + mon_dn - w0 != 0 || corr_cnt !== 4'h0 || uncorr_cnt !== 4'h0) begin
            n_fail++; $display("FAIL bypass_side: got re=%0d we=%0d corr=%h uncorr=%h want 1 0 0 0",
                               mon_re - r0, mon_both + mon_up + mon_dn - w0, corr_cnt, uncorr_cnt);
        end
    endtask

    task automatic test_scrub();
        logic [1:0]  modes [2] = '{2'b10, 2'b11};
        logic [7:0]  addrs [2] = '{8'h3C, 8'h4D};
        logic [15:0] datas [2] = '{16'hBEEF, 16'hC3C3};
        logic [2:0]  flags [2] = '{3'b001, 3'b010};
        scrub_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            int b0 = mon_both, cyc;
            bit seen;
            rd_val = datas[i]; rd_flag = flags[i];
            exp_q.push_back('{datas[i], flags[i]});
            issue(1'b0, modes[i], addrs[i], 16'h0000);
            wait_rsp(cyc, seen);
            ex = exp_q.pop_front();
            n_tests++;
            if (!seen || cyc != MEM_LAT + 3 || rsp_rdata !== ex.rdata || rsp_flag !== ex.flag || ecc_sel !== modes[i]) begin
                n_fail++; $display("FAIL scrub_rsp[%0d]: got seen=%0b lat=%0d data=%h flag=%b sel=%b want lat=%0d data=%h flag=%b sel=%b",
                                   i, seen, cyc, rsp_rdata, rsp_flag, ecc_sel, MEM_LAT + 3, ex.rdata, ex.flag, modes[i]);
            end
            ack();
            n_tests++;
            if (mon_both - b0 != 1 || last_sel !== 2'b10 || last_wdata !== datas[i] || last_addr !== addrs[i]) begin
                n_fail++; $display("FAIL scrub_write[%0d]: got n=%0d sel=%b wdata=%h addr=%h want 1 10 %h %h",
                                   i, mon_both - b0, last_sel, last_wdata, last_addr, datas[i], addrs[i]);
            end
            n_tests++;
            if (corr_cnt !== 4'(i + 1) || uncorr_cnt !== 4'h0) begin
                n_fail++; $display("FAIL scrub_cnt[%0d]: got corr=%h uncorr=%h want %h 0", i, corr_cnt, uncorr_cnt, 4'(i + 1));
            end
        end
    endtask

    task automatic test_uncorr();
        int w0 = mon_both + mon_up + mon_dn, cyc;
        bit seen;
        scrub_en = 1'b1; rd_val = 16'h5555; rd_flag = 3'b100;
        exp_q.push_back('{16'h5555, 3'b100});
        issue(1'b0, 2'b11, 8'h60, 16'h0000);
        wait_rsp(cyc, seen);
        ex = exp_q.pop_front();
        n_tests++;
        if (!seen || cyc != MEM_LAT + 2 || rsp_rdata !== ex.rdata || rsp_flag !== ex.flag) begin
            n_fail++; $display("FAIL uncorr_rsp: got seen=%0b lat=%0d data=%h flag=%b want lat=%0d data=%h flag=%b",
                               seen, cyc, rsp_rdata, rsp_flag, MEM_LAT + 2, ex.rdata, ex.flag);
        end
        ack();
        n_tests++;
        if (mon_both + mon_up + mon_dn - w0 != 0 || uncorr_cnt !== 4'h1 || corr_cnt !== 4'h2) begin
            n_fail++; $display("FAIL uncorr_side: got we=%0d uncorr=%h corr=%h want 0 1 2",
                               mon_both + mon_up + mon_dn - w0, uncorr_cnt, corr_cnt);
        end
    endtask

    task automatic test_backpressure();
        int cyc, bad = 0, u0;
        bit seen;
        scrub_en = 1'b0; rd_val = 16'h0F0F; rd_flag = 3'b000;
        exp_q.push_back('{16'h0F0F, 3'b000});
        issue(1'b0, 2'b10, 8'h22, 16'h0000);
        wait_rsp(cyc, seen);
        ex = exp_q.pop_front();
        req_valid = 1'b1; req_we = 1'b1; req_mode = 2'b00; req_addr = 8'h77; req_wdata = 16'h1111;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b1 || rsp_rdata !== ex.rdata || rsp_flag !== ex.flag ||
                req_ready !== 1'b0 || mem_we_up !== 1'b0) bad++;
            @(negedge clk);
        end
        n_tests++;
        if (!seen || bad != 0) begin
            n_fail++; $display("FAIL hold_stable: got seen=%0b unstable_cycles=%0d want 1 0", seen, bad);
        end
        u0 = mon_up;
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL hold_release: got req_ready=%b rsp_valid=%b want 1 0", req_ready, rsp_valid);
        end
        exp_q.push_back('{16'h0000, 3'b000});
        @(posedge clk); #1 req_valid = 1'b0;
        wait_rsp(cyc, seen);
        ex = exp_q.pop_front();
        n_tests++;
        if (!seen || cyc != 2 || rsp_rdata !== ex.rdata || rsp_flag !== ex.flag) begin
            n_fail++; $display("FAIL queued_write_rsp: got seen=%0b lat=%0d data=%h flag=%b want lat=2 data=0 flag=0",
                               seen, cyc, rsp_rdata, rsp_flag);
        end
        ack();
        n_tests++;
        if (mon_up - u0 != 1 || last_addr !== 8'h77 || last_wdata !== 16'h1111) begin
            n_fail++; $display("FAIL queued_write_bus: got up=%0d addr=%h wdata=%h want 1 77 1111",
                               mon_up - u0, last_addr, last_wdata);
        end
    endtask

    task automatic test_saturation();
        int cyc, bad = 0;
        bit seen;
        logic [CNT_W-1:0] exp_corr = corr_cnt;
        scrub_en = 1'b0; rd_flag = 3'b011;
        for (int i = 0; i < 15; i++) begin
            rd_val = 16'(16'h0100 + i);
            exp_q.push_back('{rd_val, 3'b011});
            exp_corr = (exp_corr == {CNT_W{1'b1}}) ? exp_corr : exp_corr + 1'b1;
            issue(1'b0, 2'b10, 8'(i), 16'h0000);
            wait_rsp(cyc, seen);
            ex = exp_q.pop_front();
            if (!seen || rsp_rdata !== ex.rdata || rsp_flag !== ex.flag) bad++;
            ack();
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL sat_rsps: got %0d bad responses want 0", bad);
        end
        n_tests++;
        if (corr_cnt !== exp_corr || corr_cnt !== 4'hF) begin
            n_fail++; $display("FAIL sat_count: got corr=%h want %h", corr_cnt, exp_corr);
        end
    endtask

    task automatic test_clear();
        int cyc;
        bit seen;
        scrub_en = 1'b0; rd_val = 16'h7E7E; rd_flag = 3'b001;
        exp_q.push_back('{16'h7E7E, 3'b001});
        issue(1'b0, 2'b10, 8'h81, 16'h0000);
        @(posedge clk);
        @(posedge clk); #1 cnt_clr = 1'b1;
        @(posedge clk); #1 cnt_clr = 1'b0;
        wait_rsp(cyc, seen);
        ex = exp_q.pop_front();
        n_tests++;
        if (!seen || cyc != 1 || rsp_rdata !== ex.rdata || rsp_flag !== ex.flag) begin
            n_fail++; $display("FAIL clear_rsp: got seen=%0b lat=%0d data=%h flag=%b want lat=1 data=%h flag=%b",
                               seen, cyc, rsp_rdata, rsp_flag, ex.rdata, ex.flag);
        end
        ack();
        n_tests++;
        if (corr_cnt !== 4'h0 || uncorr_cnt !== 4'h0) begin
            n_fail++; $display("FAIL clear_priority: got corr=%h uncorr=%h want 0 0", corr_cnt, uncorr_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        scrub_en = 1'b1; rd_val = 16'h9999; rd_flag = 3'b001;
        issue(1'b0, 2'b11, 8'h44, 16'h0000);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1 || mem_addr !== 8'h00 || ecc_sel !== 2'b10) begin
            n_fail++; $display("FAIL rst_mid_idle: got req_ready=%b addr=%h sel=%b want 1 00 10",
                               req_ready, mem_addr, ecc_sel);
        end
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid !== 1'b0 || mem_re !== 1'b0 || mem_we_up !== 1'b0 || mem_we_down !== 1'b0) bad++;
            @(negedge clk);
        end
        n_tests++;
        if (bad != 0 || corr_cnt !== 4'h0) begin
            n_fail++; $display("FAIL rst_mid_quiet: got active_cycles=%0d corr=%h want 0 0", bad, corr_cnt);
        end
    endtask

    task automatic test_exclusive();
        n_tests++;
        if (mon_ovl != 0) begin
            n_fail++; $display("FAIL strobe_overlap: got %0d overlapping cycles want 0", mon_ovl);
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_mode = 2'b00; req_addr = 8'h00;
        req_wdata = 16'h0000; rsp_ready = 1'b0; scrub_en = 1'b0; cnt_clr = 1'b0;
        test_reset();
        test_write();
        test_bypass_read();
        test_scrub();
        test_uncorr();
        test_backpressure();
        test_saturation();
        test_clear();
        test_reset_mid();
        test_exclusive();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
